// File: rtl/cdb_broadcast_arbiter.sv
// Common-data-bus arbiter: merges result writebacks from NUM_CH producer
// channels onto one registered broadcast bus. Each channel has its own FIFO
// with ready/valid backpressure. Channels are served round-robin. A flush
// discards every buffered result. A saturating counter tracks broadcasts.
module cdb_broadcast_arbiter #(
   parameter int NUM_CH     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int TAG_W      = 6,
   parameter int REG_W      = 5,
   parameter int DATA_W     = 32,
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic [NUM_CH-1:0]          in_valid,
   output logic [NUM_CH-1:0]          in_ready,
   input  logic [NUM_CH*TAG_W-1:0]    in_map,
   input  logic [NUM_CH*REG_W-1:0]    in_reg,
   input  logic [NUM_CH*DATA_W-1:0]   in_val,
   input  logic                       flush,
   output logic                       bcast_flag,
   output logic [TAG_W-1:0]           bcast_map,
   output logic [REG_W-1:0]           bcast_reg,
   output logic [DATA_W-1:0]          bcast_val,
   output logic [CH_W-1:0]            bcast_ch,
   output logic [15:0]                bcast_count
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int CNT_W   = PTR_W + 1;
   localparam int ENTRY_W = TAG_W + REG_W + DATA_W;

   logic [ENTRY_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr [NUM_CH];
   logic [PTR_W-1:0]   rd_ptr [NUM_CH];
   logic [CNT_W-1:0]   fill   [NUM_CH];

   logic [CH_W-1:0]    rr_ptr;
   logic [CH_W-1:0]    grant;
   logic [CH_W-1:0]    rr_next;
   logic               grant_valid;
   logic               pop;
   logic [NUM_CH-1:0]  pop_ch;
   logic [NUM_CH-1:0]  push;
   logic [NUM_CH-1:0]  full;
   logic [ENTRY_W-1:0] head;

   // Ready depends only on the registered fill level (never on valid or on a
   // same-cycle pop), and it is held low while reset is asserted.
   always_comb begin
      full     = '0;
      in_ready = '0;
      push     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         full[c]     = (fill[c] == CNT_W'(FIFO_DEPTH));
         in_ready[c] = RESET & ~full[c];
         push[c]     = in_valid[c] & in_ready[c] & ~flush;
      end
   end

   // Round-robin pick: the first non-empty channel at or after rr_ptr, with wrap-around.
   always_comb begin
      int idx;
      idx         = 0;
      grant_valid = 1'b0;
      grant       = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = (int'(rr_ptr) + i) % NUM_CH;
         if (!grant_valid && (fill[idx] != '0)) begin
            grant_valid = 1'b1;
            grant       = CH_W'(idx);
         end
      end
      pop    = grant_valid & ~flush;
      pop_ch = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         pop_ch[c] = pop && (grant == CH_W'(c));
      end
      head    = mem[grant][rd_ptr[grant]];
      rr_next = (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + CH_W'(1);
   end

   // FIFO storage is written on accepted pushes. It needs no reset because the
   // fill levels decide which entries are valid.
   always_ff @(posedge CLK) begin
      for (int c = 0; c < NUM_CH; c++) begin
         if (push[c]) begin
            mem[c][wr_ptr[c]] <= {in_map[c*TAG_W +: TAG_W],
                                  in_reg[c*REG_W +: REG_W],
                                  in_val[c*DATA_W +: DATA_W]};
         end
      end
   end

   // FIFO pointers and fill levels. Flush empties every channel at once.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            fill[c]   <= '0;
         end
      end else if (flush) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wr_ptr[c] <= '0;
            rd_ptr[c] <= '0;
            fill[c]   <= '0;
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) begin
               wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
            end
            if (pop_ch[c]) begin
               rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
            end
            if (push[c] && !pop_ch[c]) begin
               fill[c] <= fill[c] + CNT_W'(1);
            end else if (!push[c] && pop_ch[c]) begin
               fill[c] <= fill[c] - CNT_W'(1);
            end
         end
      end
   end

   // Registered broadcast stage, round-robin pointer and saturating broadcast counter.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rr_ptr      <= '0;
         bcast_flag  <= 1'b0;
         bcast_map   <= '0;
         bcast_reg   <= '0;
         bcast_val   <= '0;
         bcast_ch    <= '0;
         bcast_count <= '0;
      end else if (flush) begin
         rr_ptr     <= '0;
         bcast_flag <= 1'b0;
      end else if (pop) begin
         rr_ptr     <= rr_next;
         bcast_flag <= 1'b1;
         bcast_map  <= head[ENTRY_W-1 -: TAG_W];
         bcast_reg  <= head[DATA_W +: REG_W];
         bcast_val  <= head[DATA_W-1:0];
         bcast_ch   <= grant;
         if (bcast_count != 16'hFFFF) begin
            bcast_count <= bcast_count + 16'd1;
         end
      end else begin
         bcast_flag <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cdb_broadcast_arbiter.sv
// Self-checking bench for cdb_broadcast_arbiter. It uses a queue-based reference
// model: one queue per channel, a round-robin index and a saturating counter.
module tb_cdb_broadcast_arbiter;

   localparam int NUM_CH     = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int TAG_W      = 6;
   localparam int REG_W      = 5;
   localparam int DATA_W     = 32;
   localparam int CH_W       = 1;
   localparam int ENTRY_W    = TAG_W + REG_W + DATA_W;

   logic                     CLK;
   logic                     RESET;
   logic [NUM_CH-1:0]        in_valid;
   logic [NUM_CH-1:0]        in_ready;
   logic [NUM_CH*TAG_W-1:0]  in_map;
   logic [NUM_CH*REG_W-1:0]  in_reg;
   logic [NUM_CH*DATA_W-1:0] in_val;
   logic                     flush;
   logic                     bcast_flag;
   logic [TAG_W-1:0]         bcast_map;
   logic [REG_W-1:0]         bcast_reg;
   logic [DATA_W-1:0]        bcast_val;
   logic [CH_W-1:0]          bcast_ch;
   logic [15:0]              bcast_count;

   int checks = 0;
   int errors = 0;

   logic [ENTRY_W-1:0] mq [NUM_CH][$];
   int                 m_rr;
   logic               m_flag;
   logic [TAG_W-1:0]   m_map;
   logic [REG_W-1:0]   m_reg;
   logic [DATA_W-1:0]  m_val;
   int                 m_ch;
   int                 m_cnt;

   bit                 log_en;
   logic [39:0]        obs_log [$];
   bit                 seen_full;

   cdb_broadcast_arbiter #(
      .NUM_CH(NUM_CH), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W),
      .REG_W(REG_W), .DATA_W(DATA_W)
   ) dut (
      .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
      .in_map(in_map), .in_reg(in_reg), .in_val(in_val), .flush(flush),
      .bcast_flag(bcast_flag), .bcast_map(bcast_map), .bcast_reg(bcast_reg),
      .bcast_val(bcast_val), .bcast_ch(bcast_ch), .bcast_count(bcast_count)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_rr   = 0;
      m_flag = 1'b0;
      m_map  = '0;
      m_reg  = '0;
      m_val  = '0;
      m_ch   = 0;
      m_cnt  = 0;
   endtask

   // Apply the specified behaviour for one rising edge, using the current inputs.
   task automatic model_edge();
      logic [NUM_CH-1:0]  rdy;
      logic [ENTRY_W-1:0] e;
      int                 g;
      for (int c = 0; c < NUM_CH; c++) rdy[c] = (mq[c].size() < FIFO_DEPTH);
      if (flush) begin
         for (int c = 0; c < NUM_CH; c++) mq[c].delete();
         m_rr   = 0;
         m_flag = 1'b0;
      end else begin
         g = -1;
         for (int k = 0; k < NUM_CH; k++) begin
            int cand;
            cand = (m_rr + k) % NUM_CH;
            if (g < 0 && mq[cand].size() > 0) g = cand;
         end
         if (g >= 0) begin
            e      = mq[g].pop_front();
            m_flag = 1'b1;
            m_map  = e[ENTRY_W-1 -: TAG_W];
            m_reg  = e[DATA_W +: REG_W];
            m_val  = e[DATA_W-1:0];
            m_ch   = g;
            if (m_cnt < 65535) m_cnt++;
            m_rr   = (g + 1) % NUM_CH;
         end else begin
            m_flag = 1'b0;
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (in_valid[c] && rdy[c])
               mq[c].push_back({in_map[c*TAG_W +: TAG_W], in_reg[c*REG_W +: REG_W],
                                in_val[c*DATA_W +: DATA_W]});
         end
      end
   endtask

   task automatic checkOutput(input string tag);
      logic [NUM_CH-1:0] exp_rdy;
      for (int c = 0; c < NUM_CH; c++) exp_rdy[c] = RESET && (mq[c].size() < FIFO_DEPTH);
      chk({tag, ".in_ready"}, 64'(in_ready), 64'(exp_rdy));
      chk({tag, ".flag"}, 64'(bcast_flag), 64'(m_flag));
      chk({tag, ".map"}, 64'(bcast_map), 64'(m_map));
      chk({tag, ".reg"}, 64'(bcast_reg), 64'(m_reg));
      chk({tag, ".val"}, 64'(bcast_val), 64'(m_val));
      chk({tag, ".ch"}, 64'(bcast_ch), 64'(m_ch));
      chk({tag, ".count"}, 64'(bcast_count), 64'(m_cnt));
      if (log_en && bcast_flag) obs_log.push_back({7'(bcast_ch), 1'b0, bcast_val});
      if (!in_ready[1]) seen_full = 1'b1;
   endtask

   task automatic step(input string tag);
      model_edge();
      @(posedge CLK);
      #1;
      checkOutput(tag);
   endtask

   task automatic applyStimulus(input int c, input logic v, input logic [TAG_W-1:0] m,
                                input logic [REG_W-1:0] r, input logic [DATA_W-1:0] d);
      in_valid[c]                = v;
      in_map[c*TAG_W +: TAG_W]   = m;
      in_reg[c*REG_W +: REG_W]   = r;
      in_val[c*DATA_W +: DATA_W] = d;
   endtask

   task automatic idle();
      in_valid = '0;
      flush    = 1'b0;
   endtask

   task automatic randomInputs(input bit all_valid);
      for (int c = 0; c < NUM_CH; c++)
         applyStimulus(c, all_valid ? 1'b1 : 1'($urandom_range(0, 1)),
                       TAG_W'($urandom), REG_W'($urandom), $urandom);
   endtask

   initial begin
      RESET    = 1'b0;
      in_valid = '1;
      in_map   = '0;
      in_reg   = '0;
      in_val   = '0;
      flush    = 1'b0;
      log_en   = 1'b0;
      seen_full = 1'b0;
      model_reset();

      // Reset held with valid asserted: nothing is ready, the broadcast bus is idle.
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("reset");
      RESET = 1'b1;
      #1;
      chk("reset_release.in_ready", 64'(in_ready), 64'h3);
      idle();

      // A single push appears on the bus one edge after it is accepted.
      applyStimulus(0, 1'b1, 6'h05, 5'd3, 32'hDEADBEEF);
      step("single_push");
      chk("single.flag_k", 64'(bcast_flag), 64'h0);
      idle();
      step("single_bcast");
      chk("single.flag", 64'(bcast_flag), 64'h1);
      chk("single.map", 64'(bcast_map), 64'h05);
      chk("single.reg", 64'(bcast_reg), 64'h3);
      chk("single.val", 64'(bcast_val), 64'hDEADBEEF);
      chk("single.ch", 64'(bcast_ch), 64'h0);
      step("single_after");
      chk("single.flag_next", 64'(bcast_flag), 64'h0);
      chk("single.count", 64'(bcast_count), 64'h1);

      // Contention: a flush resets the round-robin pointer, then both channels push three entries.
      flush = 1'b1;
      step("cont_flush");
      flush = 1'b0;
      obs_log.delete();
      log_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1'b1, 6'(i), 5'(i), 32'h100 + i);
         applyStimulus(1, 1'b1, 6'(i + 8), 5'(i + 8), 32'h200 + i);
         step("cont_push");
      end
      idle();
      repeat (8) step("cont_drain");
      chk("cont.num", 64'(obs_log.size()), 64'd6);
      for (int i = 0; i < 6 && i < obs_log.size(); i++)
         chk("cont.order", 64'(obs_log[i]), {24'h0, 7'(i % 2), 1'b0, 32'h100 * (i % 2 + 1) + 32'(i / 2)});
      chk("cont.count", 64'(bcast_count), 64'd7);
      log_en = 1'b0;

      // Backpressure: both channels stream so ch1 fills up under round-robin draining.
      seen_full = 1'b0;
      for (int i = 0; i < 14; i++) begin
         randomInputs(1'b1);
         step("bp_stream");
      end
      idle();
      repeat (10) step("bp_drain");
      chk("bp.ch1_full_seen", 64'(seen_full), 64'h1);

      // Flush: buffered entries and pushes in the flush cycle must never reach the bus.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(0, 1'b1, 6'h3F, 5'h1F, 32'hBAD0_0000 + i);
         applyStimulus(1, i < 2, 6'h3E, 5'h1E, 32'hBAD1_0000 + i);
         step("fl_fill");
      end
      applyStimulus(0, 1'b1, 6'h3D, 5'h1D, 32'hBAD2_0000);
      applyStimulus(1, 1'b1, 6'h3C, 5'h1C, 32'hBAD3_0000);
      flush = 1'b1;
      step("fl_edge");
      chk("flush.flag", 64'(bcast_flag), 64'h0);
      chk("flush.in_ready", 64'(in_ready), 64'h3);
      idle();
      obs_log.delete();
      log_en = 1'b1;
      repeat (6) step("fl_quiet");
      chk("flush.no_stale", 64'(obs_log.size()), 64'd0);
      applyStimulus(0, 1'b1, 6'h01, 5'd1, 32'h55);
      applyStimulus(1, 1'b1, 6'h02, 5'd2, 32'h66);
      step("fl_repush");
      idle();
      repeat (3) step("fl_repush_drain");
      chk("flush.rr_num", 64'(obs_log.size()), 64'd2);
      if (obs_log.size() >= 2) begin
         chk("flush.rr_first", 64'(obs_log[0]), {24'h0, 8'h00, 32'h55});
         chk("flush.rr_second", 64'(obs_log[1]), {24'h0, 8'h02, 32'h66});
      end
      log_en = 1'b0;

      // Randomised traffic with occasional flushes and one asynchronous reset mid-stream.
      for (int i = 0; i < 2000; i++) begin
         randomInputs(1'b0);
         flush = ($urandom_range(0, 39) == 0);
         if (i == 1000) begin
            #2;
            RESET = 1'b0;
            #1;
            model_reset();
            checkOutput("async_reset");
            @(posedge CLK);
            #1;
            checkOutput("async_reset_hold");
            RESET = 1'b1;
            #1;
         end
         step("random");
      end
      flush = 1'b0;

      // Saturation: stream continuously until the counter has to stick at FFFF.
      for (int i = 0; i < 65600; i++) begin
         randomInputs(1'b1);
         step("sat");
      end
      chk("sat.count", 64'(bcast_count), 64'hFFFF);
      idle();
      repeat (4) step("sat_tail");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
